// File: rtl/aes_inv_sub_bytes.sv
// AES InvSubBytes engine: 128-bit state, LANES bytes substituted per cycle.
// Ports: clk_i, reset_n_i, v_i/data_i/ready_o in, v_o/data_o/yumi_i out.
module aes_inv_sub_bytes #(
  parameter int LANES = 1
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         v_i,
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic         v_o,
  output logic [127:0] data_o,
  input  logic         yumi_i
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  work_q;
  logic [127:0]  work_d;
  logic          ready_q;
  logic          v_q;
  logic [7:0]    lane_out [LANES];

  // Only LANES substitution boxes: the current group is muxed out of
  // the work register, substituted, and written back in place.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_out[l] =
        INV_SBOX[work_q[8*(int'(cnt_q)*LANES+l) +: 8]];
    end
    work_d = work_q;
    for (int k = 0; k < 16; k++) begin
      if ((k / LANES) == int'(cnt_q)) begin
        work_d[8*k +: 8] = lane_out[k % LANES];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      ready_q <= 1'b1;
      v_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (v_i) begin
            work_q  <= data_i;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          work_q <= work_d;
          if (cnt_q == LAST) begin
            v_q     <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (yumi_i) begin
            v_q     <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          v_q     <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign v_o     = v_q;
  assign data_o  = work_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Bench for aes_inv_sub_bytes: all five LANES variants side by side,
// checked against an InvSbox derived from GF(2^8) arithmetic.
module tb_aes_inv_sub_bytes;

  localparam int NI = 5;

  logic         clk;
  logic         reset_n;
  logic         v_i;
  logic [127:0] data_i;
  logic         yumi_i;
  logic         ready_w [NI];
  logic         v_w [NI];
  logic [127:0] data_w [NI];

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]   fwd_m [256];
  logic [7:0]   inv_m [256];
  int           lat_r [NI];
  logic [127:0] res_r [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_inv_sub_bytes #(.LANES(1 << g)) u_dut (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .v_i      (v_i),
      .data_i   (data_i),
      .ready_o  (ready_w[g]),
      .v_o      (v_w[g]),
      .data_o   (data_w[g]),
      .yumi_i   (yumi_i)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Forward S-box from multiplicative inverse + affine map,
  // then inverted by table lookup.
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      fwd_m[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3)
               ^ rotl(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);
  endtask

  function automatic logic [127:0] exp_block(logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_m[d[8*k +: 8]];
    return r;
  endfunction

  function automatic int exp_lat(int i);
    return 16 / (1 << i) + 1;
  endfunction

  // Drives one block from a negedge and records, per instance, the
  // number of edges (accepting edge = 1) until v_o and the data then.
  task automatic send_block(input logic [127:0] d, input bit poke,
                            input bit rel);
    int n = 0;
    int left = NI;
    for (int i = 0; i < NI; i++) begin
      lat_r[i] = 0;
      res_r[i] = '0;
    end
    v_i = 1'b1;
    data_i = d;
    while (n < 40 && left > 0) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (lat_r[i] == 0 && v_w[i] === 1'b1) begin
          lat_r[i] = n;
          res_r[i] = data_w[i];
          left--;
        end
      end
      if (n == 1 && poke) begin
        v_i = 1'b1;
        yumi_i = 1'b1;
        data_i = ~d;
      end else begin
        v_i = 1'b0;
        yumi_i = 1'b0;
      end
    end
    if (rel) begin
      yumi_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      yumi_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (ready_w[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready[%0d] got %b want 1", i, ready_w[i]);
      end
      n_checks++;
      if (v_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_v[%0d] got %b want 0", i, v_w[i]);
      end
      n_checks++;
      if (data_w[i] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_data[%0d] got %h want 0", i, data_w[i]);
      end
    end
  endtask

  task automatic test_block(input string nm, input logic [127:0] d,
                            input logic [127:0] want);
    send_block(d, 1'b0, 1'b1);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (res_r[i] !== want) begin
        n_fail++;
        $display("FAIL %s_data[%0d] got %h want %h",
                 nm, i, res_r[i], want);
      end
      n_checks++;
      if (lat_r[i] !== exp_lat(i)) begin
        n_fail++;
        $display("FAIL %s_lat[%0d] got %0d want %0d",
                 nm, i, lat_r[i], exp_lat(i));
      end
      n_checks++;
      if (ready_w[i] !== 1'b1 || v_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_release[%0d] got rdy=%b v=%b want 1/0",
                 nm, i, ready_w[i], v_w[i]);
      end
    end
  endtask

  task automatic test_all_63();
    test_block("all63", {16{8'h63}}, 128'h0);
  endtask

  task automatic test_sbox_ident();
    logic [127:0] d;
    logic [127:0] w;
    for (int k = 0; k < 16; k++) begin
      d[8*k +: 8] = fwd_m[k];
      w[8*k +: 8] = 8'(k);
    end
    test_block("ident", d, w);
  endtask

  task automatic test_mixed();
    test_block("mixed", {{13{8'h63}}, 8'h16, 8'hed, 8'h00},
               {{13{8'h00}}, 8'hff, 8'h53, 8'h52});
  endtask

  task automatic test_ignore_busy();
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    send_block(d, 1'b1, 1'b1);
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (res_r[i] !== exp_block(d) || lat_r[i] !== exp_lat(i)) begin
        n_fail++;
        $display("FAIL ignore_busy[%0d] got %h/%0d want %h/%0d", i,
                 res_r[i], lat_r[i], exp_block(d), exp_lat(i));
      end
    end
    yumi_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi_i = 1'b0;
    n_checks++;
    if (ready_w[0] !== 1'b1 || v_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL yumi_idle got rdy=%b v=%b want 1/0",
               ready_w[0], v_w[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] b = {$urandom, $urandom, $urandom, $urandom};
    send_block(a, 1'b0, 1'b0);
    v_i = 1'b1;
    data_i = b;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (v_w[i] !== 1'b1 || ready_w[i] !== 1'b0 ||
            data_w[i] !== exp_block(a)) begin
          n_fail++;
          $display("FAIL hold[%0d] c%0d got v=%b rdy=%b %h want 1/0 %h",
                   i, c, v_w[i], ready_w[i], data_w[i], exp_block(a));
        end
      end
    end
    yumi_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi_i = 1'b0;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (ready_w[i] !== 1'b1 || v_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL after_yumi[%0d] got rdy=%b v=%b want 1/0",
                 i, ready_w[i], v_w[i]);
      end
    end
    test_block("second", b, exp_block(b));
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    v_i = 1'b1;
    data_i = d;
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    n_checks++;
    if (v_w[0] !== 1'b0 || ready_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_busy got v=%b rdy=%b want 0/0",
               v_w[0], ready_w[0]);
    end
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (v_w[i] !== 1'b0 || ready_w[i] !== 1'b1 ||
          data_w[i] !== 128'h0) begin
        n_fail++;
        $display("FAIL async_reset[%0d] got v=%b rdy=%b %h want 0/1/0",
                 i, v_w[i], ready_w[i], data_w[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    test_block("post_reset", ~d, exp_block(~d));
  endtask

  task automatic test_all_bytes();
    logic [7:0] perm [256];
    logic [127:0] d;
    for (int x = 0; x < 256; x++) perm[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      int j = int'($urandom_range(x, 0));
      logic [7:0] t = perm[x];
      perm[x] = perm[j];
      perm[j] = t;
    end
    for (int blk = 0; blk < 16; blk++) begin
      for (int k = 0; k < 16; k++) d[8*k +: 8] = perm[16*blk + k];
      test_block("allbytes", d, exp_block(d));
    end
  endtask

  task automatic test_random();
    logic [127:0] d;
    for (int r = 0; r < 6; r++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      test_block("random", d, exp_block(d));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    v_i = 1'b0;
    yumi_i = 1'b0;
    data_i = '0;
    build_model();
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_all_63();
    test_sbox_ident();
    test_mixed();
    test_ignore_busy();
    test_backpressure();
    test_reset_mid_busy();
    test_all_bytes();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_inv_sub_bytes.md
AES_INV_SUB_BYTES -- requirements
Module: aes_inv_sub_bytes

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port v_i, input, 1 bit: the input state block is valid.
REQ-005 SHALL have port data_i, input, 128 bits: the input state; byte k is data_i[8k+7:8k], for k = 0..15.
REQ-006 SHALL have port ready_o, output, 1 bit: the block can accept an input this cycle.
REQ-007 SHALL have port v_o, output, 1 bit: data_o holds a completed result.
REQ-008 SHALL have port data_o, output, 128 bits: the result; byte k = InvSbox(data_i byte k).
REQ-009 SHALL have port yumi_i, input, 1 bit: the consumer takes the result; legal only while v_o=1.

Function
REQ-010 SHALL apply InvSbox per FIPS-197 Fig. 14, the exact inverse of the forward S-box, so that InvSbox(Sbox(x)) = x for all 256 values of x.
REQ-011 SHALL implement the FSM states IDLE, BUSY and DONE; ready_o=1 only in IDLE, and v_o=1 only in DONE.
REQ-012 SHALL, in IDLE, capture data_i into a 128-bit work register when v_i=1, clear the lane counter to 0 and go to BUSY; with v_i=0 it stays in IDLE.
REQ-013 SHALL, in each BUSY cycle, replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the work register with their InvSbox values, then increment cnt.
REQ-014 SHALL size cnt at max(1, log2(16/LANES)) bits and leave BUSY for DONE in the cycle that processes the last group (cnt = 16/LANES-1); cnt never wraps while in BUSY.
REQ-015 SHALL give a latency of exactly 16/LANES BUSY cycles, so v_o rises 16/LANES+1 edges after the accepting edge (17 for LANES=1, 2 for LANES=16).
REQ-016 SHALL drive data_o directly from the work register, and hold it stable while v_o=1.
REQ-017 SHALL, in DONE with yumi_i=1, return to IDLE on the next edge; with yumi_i=0, hold DONE and data_o indefinitely.
REQ-018 SHALL not accept a new input in the same cycle as yumi_i; throughput is one block per 16/LANES+2 cycles.
REQ-019 SHALL ignore v_i outside IDLE: no capture and no state change.
REQ-020 SHALL ignore yumi_i outside DONE.
REQ-021 SHALL produce identical data_o for every legal LANES value, given the same data_i.

Reset
REQ-022 SHALL, while reset_n_i=0, force the following regardless of clk_i: state=IDLE, cnt=0, work register=0, ready_o=1, v_o=0, data_o=128'h0.
REQ-023 SHALL, on reset asserted mid-BUSY or in DONE, immediately abandon the block in progress; no result for that block is ever presented.
REQ-024 SHALL accept a new input on the first rising edge after reset_n_i deasserts, if v_i=1 at that edge.

Verification
REQ-025 SHALL be checked with this scenario: data_i all bytes 8'h63, v_i pulse, LANES=1 -> v_o=1 after 17 edges, data_o=128'h0.
REQ-026 SHALL be checked with this scenario: byte k = forward Sbox(k) for k=0..15 (0x63,0x7c,0x77,...,0x76) -> data_o byte k = k, i.e. 128'h0f0e...0100.
REQ-027 SHALL be checked with this scenario: data_i bytes 0x00, 0xed, 0x16 in positions 0..2, rest 0x63 -> data_o bytes 0x52, 0x53, 0xff, rest 0x00.
REQ-028 SHALL be checked with this scenario: yumi_i held 0 for 10 cycles in DONE with v_i=1 throughout -> v_o stays 1, data_o stable, ready_o=0, and the second block is accepted only after yumi_i.
REQ-029 SHALL be checked with this scenario: reset_n_i pulsed low at BUSY cnt=7 -> v_o=0 and data_o=0 immediately; the next block completes correctly with full latency.
REQ-030 SHALL be checked with this scenario: all 256 byte values over 16 blocks, run for each of LANES = 1, 2, 4, 8, 16 -> outputs match a golden InvSbox model, with latencies 17, 9, 5, 3, 2.
